// File: rtl/pong_game_ctrl.sv
// Pong game controller: game-state FSM, paddle positions, scoring and serve handling.
// Optional pause feature: define PONG_PAUSE_EN to let keycode 0 toggle PLAY <-> PAUSE.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int PADDLE_MAX   = 400,
    parameter int PADDLE_STEP  = 4,
    parameter int POINT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] keys_1,
    input  logic [3:0] keys_2,
    input  logic       key_pressed_1,
    input  logic       key_pressed_2,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [8:0] paddle_1_y,
    output logic [8:0] paddle_2_y,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic       ball_en,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [2:0] state,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

    localparam int          CNT_W      = (POINT_FRAMES > 1) ? $clog2(POINT_FRAMES) : 1;
    localparam logic [8:0]  P_MAX      = 9'(PADDLE_MAX);
    localparam logic [8:0]  P_MID      = 9'(PADDLE_MAX / 2);
    localparam logic [8:0]  P_STEP     = 9'(PADDLE_STEP);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POINT_FRAMES - 1);

    state_t             cur_state, next_state;
    logic               key_prev_1, key_prev_2;
    logic [CNT_W-1:0]   point_cnt;

    // Key events are the rising edge of key_pressed, with the keycode sampled alongside.
    logic key_rise_1, key_rise_2;
    logic serve_1, serve_2, serve_any, serve_ok;
    logic miss_any, point_done, game_won, enter_idle, paddle_move;

    assign key_rise_1 = key_pressed_1 & ~key_prev_1;
    assign key_rise_2 = key_pressed_2 & ~key_prev_2;
    assign serve_1    = key_rise_1 && (keys_1 == 4'd5);
    assign serve_2    = key_rise_2 && (keys_2 == 4'd5);
    assign serve_any  = serve_1 | serve_2;
    assign serve_ok   = serve_dir ? serve_1 : serve_2;
    assign miss_any   = miss_left | miss_right;
    assign point_done = frame_tick && (point_cnt == CNT_LAST);
    assign game_won   = (score_1 >= WIN) || (score_2 >= WIN);
    assign enter_idle = (next_state == S_IDLE) && (cur_state != S_IDLE);
    assign paddle_move = frame_tick && ((cur_state == S_SERVE) || (cur_state == S_PLAY));

`ifdef PONG_PAUSE_EN
    logic pause_ev;
    assign pause_ev = (key_rise_1 && (keys_1 == 4'd0)) || (key_rise_2 && (keys_2 == 4'd0));
`endif

    assign state = cur_state;

    // Paddle step with saturation at 0 (up) and PADDLE_MAX (down).
    function automatic logic [8:0] next_paddle(input logic [8:0] y, input logic up, input logic down);
        logic [9:0] sum;
        sum = {1'b0, y} + 10'(PADDLE_STEP);
        if (up)
            return (y < P_STEP) ? 9'd0 : y - P_STEP;
        else if (down)
            return (sum > 10'(PADDLE_MAX)) ? P_MAX : sum[8:0];
        return y;
    endfunction

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_state <= S_IDLE;
        else     cur_state <= next_state;
    end

    // Next-state logic; a miss outranks any serve or pause seen in the same cycle.
    // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_IDLE:  if (serve_any) next_state = S_SERVE;
            S_SERVE: if (serve_ok)  next_state = S_PLAY;
            S_PLAY: begin
                if (miss_any) next_state = S_POINT;
`ifdef PONG_PAUSE_EN
                else if (pause_ev) next_state = S_PAUSE;
`endif
            end
            S_POINT: if (point_done) next_state = game_won ? S_OVER : S_SERVE;
            S_OVER:  if (serve_any) next_state = S_IDLE;
`ifdef PONG_PAUSE_EN
            S_PAUSE: if (pause_ev) next_state = S_PLAY;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic: the ball only moves during live play.
    always_comb begin
        ball_en = (cur_state == S_PLAY);
    end

    // Key-edge history and the one-cycle ball recentre pulse on each entry into SERVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_prev_1 <= 1'b0;
            key_prev_2 <= 1'b0;
            ball_reset <= 1'b0;
        end else begin
            key_prev_1 <= key_pressed_1;
            key_prev_2 <= key_pressed_2;
            ball_reset <= (next_state == S_SERVE) && (cur_state != S_SERVE);
        end
    end

    // Frame counter for the between-points delay; idle at 0 outside POINT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            point_cnt <= '0;
        else if (cur_state != S_POINT)
            point_cnt <= '0;
        else if (frame_tick)
            point_cnt <= point_done ? '0 : point_cnt + CNT_W'(1);
    end

    // Scores, serve direction and winner; a double miss scores nobody.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_1   <= 4'd0;
            score_2   <= 4'd0;
            serve_dir <= 1'b0;
            winner    <= 2'd0;
        end else if (enter_idle) begin
            score_1 <= 4'd0;
            score_2 <= 4'd0;
            winner  <= 2'd0;
        end else if ((cur_state == S_PLAY) && (miss_left ^ miss_right)) begin
            if (miss_left) begin
                if (score_2 != 4'd15) score_2 <= score_2 + 4'd1;
                serve_dir <= 1'b1;
            end else begin
                if (score_1 != 4'd15) score_1 <= score_1 + 4'd1;
                serve_dir <= 1'b0;
            end
        end else if ((cur_state == S_POINT) && point_done && game_won) begin
            winner <= (score_1 >= WIN) ? 2'd1 : 2'd2;
        end
    end

    // Paddle positions: recentred on entry to IDLE, stepped once per frame in SERVE/PLAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddle_1_y <= P_MID;
            paddle_2_y <= P_MID;
        end else if (enter_idle) begin
            paddle_1_y <= P_MID;
            paddle_2_y <= P_MID;
        end else if (paddle_move) begin
            paddle_1_y <= next_paddle(paddle_1_y, key_pressed_1 && (keys_1 == 4'd2),
                                      key_pressed_1 && (keys_1 == 4'd8));
            paddle_2_y <= next_paddle(paddle_2_y, key_pressed_2 && (keys_2 == 4'd2),
                                      key_pressed_2 && (keys_2 == 4'd8));
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a directed vector table followed by
// hand-written multi-cycle sequences (point delay, paddle saturation, game over, pause, reset).
module tb_pong_game_ctrl;

    localparam int POINT_FRAMES = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [3:0] keys_1, keys_2;
    logic       key_pressed_1, key_pressed_2;
    logic       miss_left, miss_right;
    logic [8:0] paddle_1_y, paddle_2_y;
    logic [3:0] score_1, score_2;
    logic       ball_en, ball_reset, serve_dir;
    logic [2:0] state;
    logic [1:0] winner;

    int n_pass  = 0;
    int n_total = 0;

    pong_game_ctrl #(
        .WIN_SCORE(5), .PADDLE_MAX(400), .PADDLE_STEP(4), .POINT_FRAMES(POINT_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .keys_1(keys_1), .keys_2(keys_2),
        .key_pressed_1(key_pressed_1), .key_pressed_2(key_pressed_2),
        .miss_left(miss_left), .miss_right(miss_right),
        .paddle_1_y(paddle_1_y), .paddle_2_y(paddle_2_y),
        .score_1(score_1), .score_2(score_2),
        .ball_en(ball_en), .ball_reset(ball_reset), .serve_dir(serve_dir),
        .state(state), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] k1; logic p1; logic [3:0] k2; logic p2;
        logic ml; logic mr; logic tk;
        int st; int be; int br; int sd; int y1; int y2; int s1; int s2;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [3:0] k1, input logic p1, input logic [3:0] k2, input logic p2,
                                input logic ml, input logic mr, input logic tk,
                                input int st, input int be, input int br, input int sd,
                                input int y1, input int y2, input int s1, input int s2);
        vec_t v;
        v.k1 = k1; v.p1 = p1; v.k2 = k2; v.p2 = p2; v.ml = ml; v.mr = mr; v.tk = tk;
        v.st = st; v.be = be; v.br = br; v.sd = sd; v.y1 = y1; v.y2 = y2; v.s1 = s1; v.s2 = s2;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        frame_tick = 0; keys_1 = 0; keys_2 = 0; key_pressed_1 = 0; key_pressed_2 = 0;
        miss_left = 0; miss_right = 0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1; step();
            frame_tick = 0; step();
        end
    endtask

    task automatic press(input int player, input logic [3:0] code);
        if (player == 1) begin keys_1 = code; key_pressed_1 = 1; end
        else             begin keys_2 = code; key_pressed_2 = 1; end
        step();
        key_pressed_1 = 0; key_pressed_2 = 0;
        step();
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_left = l; miss_right = r; step();
        miss_left = 0; miss_right = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // k1 p1 k2 p2 ml mr tk | st be br sd y1 y2 s1 s2
        tbl[0]  = mk(4'd8, 1, 4'd0, 0, 0, 0, 1,  0, 0, 0, 0, 200, 200, 0, 0); // IDLE: no paddle motion
        tbl[1]  = mk(4'd0, 0, 4'd0, 0, 0, 0, 0,  0, 0, 0, 0, 200, 200, 0, 0);
        tbl[2]  = mk(4'd5, 1, 4'd0, 0, 0, 0, 0,  1, 0, 1, 0, 200, 200, 0, 0); // serve -> SERVE, pulse
        tbl[3]  = mk(4'd5, 0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 200, 200, 0, 0); // pulse is one cycle
        tbl[4]  = mk(4'd5, 1, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 200, 200, 0, 0); // wrong server ignored
        tbl[5]  = mk(4'd0, 0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 200, 200, 0, 0);
        tbl[6]  = mk(4'd0, 0, 4'd8, 1, 0, 0, 1,  1, 0, 0, 0, 200, 204, 0, 0); // paddle moves in SERVE
        tbl[7]  = mk(4'd0, 0, 4'd0, 0, 0, 0, 0,  1, 0, 0, 0, 200, 204, 0, 0);
        tbl[8]  = mk(4'd0, 0, 4'd5, 1, 0, 0, 0,  2, 1, 0, 0, 200, 204, 0, 0); // player 2 serves -> PLAY
        tbl[9]  = mk(4'd0, 0, 4'd0, 0, 0, 0, 0,  2, 1, 0, 0, 200, 204, 0, 0);
        tbl[10] = mk(4'd8, 1, 4'd0, 0, 0, 0, 1,  2, 1, 0, 0, 204, 204, 0, 0); // down
        tbl[11] = mk(4'd2, 1, 4'd0, 0, 0, 0, 1,  2, 1, 0, 0, 200, 204, 0, 0); // up, level-held
        tbl[12] = mk(4'd2, 1, 4'd0, 0, 0, 0, 0,  2, 1, 0, 0, 200, 204, 0, 0); // no tick, no move
        tbl[13] = mk(4'd2, 0, 4'd0, 0, 0, 0, 1,  2, 1, 0, 0, 200, 204, 0, 0); // released, no move
        tbl[14] = mk(4'd0, 0, 4'd2, 1, 0, 0, 1,  2, 1, 0, 0, 200, 200, 0, 0);
        tbl[15] = mk(4'd0, 0, 4'd2, 0, 1, 1, 0,  3, 0, 0, 0, 200, 200, 0, 0); // double miss -> POINT only

        clear_inputs();
        rst = 1;
        step(); step();
        check("reset state", int'(state), 0);
        check("reset paddle_1_y", int'(paddle_1_y), 200);
        check("reset paddle_2_y", int'(paddle_2_y), 200);
        check("reset score_1", int'(score_1), 0);
        check("reset winner", int'(winner), 0);
        check("reset ball_reset", int'(ball_reset), 0);
        check("reset ball_en", int'(ball_en), 0);
        rst = 0;
        step();

        for (int i = 0; i < 16; i++) begin
            keys_1 = tbl[i].k1; key_pressed_1 = tbl[i].p1;
            keys_2 = tbl[i].k2; key_pressed_2 = tbl[i].p2;
            miss_left = tbl[i].ml; miss_right = tbl[i].mr; frame_tick = tbl[i].tk;
            step();
            check($sformatf("v%0d state", i), int'(state), tbl[i].st);
            check($sformatf("v%0d ball_en", i), int'(ball_en), tbl[i].be);
            check($sformatf("v%0d ball_reset", i), int'(ball_reset), tbl[i].br);
            check($sformatf("v%0d serve_dir", i), int'(serve_dir), tbl[i].sd);
            check($sformatf("v%0d paddle_1_y", i), int'(paddle_1_y), tbl[i].y1);
            check($sformatf("v%0d paddle_2_y", i), int'(paddle_2_y), tbl[i].y2);
            check($sformatf("v%0d score_1", i), int'(score_1), tbl[i].s1);
            check($sformatf("v%0d score_2", i), int'(score_2), tbl[i].s2);
        end
        clear_inputs();
        step();

        // POINT lasts exactly POINT_FRAMES ticks, then SERVE with a recentre pulse.
        tick_n(POINT_FRAMES - 1);
        check("point hold before last tick", int'(state), 3);
        frame_tick = 1; step();
        check("point -> serve", int'(state), 1);
        check("serve entry ball_reset", int'(ball_reset), 1);
        frame_tick = 0; step();
        check("serve ball_reset drops", int'(ball_reset), 0);

        // Miss outside PLAY ignored.
        pulse_miss(1, 0); step();
        check("miss in SERVE state", int'(state), 1);
        check("miss in SERVE score_2", int'(score_2), 0);

        // Player 2 serves; hold up on player 1 from 200 until saturation.
        press(2, 4'd5);
        check("serve -> play", int'(state), 2);
        keys_1 = 4'd2; key_pressed_1 = 1;
        tick_n(49);
        check("paddle_1 after 49 ticks", int'(paddle_1_y), 4);
        tick_n(1);
        check("paddle_1 after 50 ticks", int'(paddle_1_y), 0);
        tick_n(10);
        check("paddle_1 saturated at 0", int'(paddle_1_y), 0);
        key_pressed_1 = 0; keys_1 = 0; step();

        // miss_right: player 1 scores, player 2 to serve.
        pulse_miss(0, 1);
        check("miss_right state", int'(state), 3);
        check("miss_right score_1", int'(score_1), 1);
        check("miss_right serve_dir", int'(serve_dir), 0);
        check("miss_right ball_en", int'(ball_en), 0);
        tick_n(POINT_FRAMES);
        check("after point -> serve", int'(state), 1);

        // miss_left: player 2 scores, player 1 must serve next.
        press(2, 4'd5);
        pulse_miss(1, 0);
        check("miss_left score_2", int'(score_2), 1);
        check("miss_left serve_dir", int'(serve_dir), 1);
        tick_n(POINT_FRAMES);
        press(2, 4'd5);
        check("player 2 cannot serve", int'(state), 1);
        press(1, 4'd5);
        check("player 1 serves", int'(state), 2);

        // Player 1 wins 5-1.
        for (int i = 0; i < 4; i++) begin
            pulse_miss(0, 1);
            tick_n(POINT_FRAMES);
            if (i < 3) press(2, 4'd5);
        end
        check("final score_1", int'(score_1), 5);
        check("final score_2", int'(score_2), 1);
        check("game over state", int'(state), 4);
        check("winner", int'(winner), 1);
        check("game over ball_en", int'(ball_en), 0);

        // Serve in OVER returns to IDLE and clears the game.
        press(1, 4'd5);
        check("over -> idle", int'(state), 0);
        check("idle score_1", int'(score_1), 0);
        check("idle score_2", int'(score_2), 0);
        check("idle winner", int'(winner), 0);
        check("idle paddle_1_y", int'(paddle_1_y), 200);
        check("idle paddle_2_y", int'(paddle_2_y), 200);

        // Pause behaviour.
        press(1, 4'd5);
        press(2, 4'd5);
        check("new game play", int'(state), 2);
        press(1, 4'd0);
`ifdef PONG_PAUSE_EN
        check("pause state", int'(state), 5);
        check("pause ball_en", int'(ball_en), 0);
        pulse_miss(1, 0); step();
        check("miss in pause state", int'(state), 5);
        check("miss in pause score_2", int'(score_2), 0);
        press(2, 4'd0);
        check("unpause state", int'(state), 2);
`else
        check("key 0 ignored state", int'(state), 2);
        check("key 0 ignored ball_en", int'(ball_en), 1);
`endif

        // Reset mid-game discards progress; next key event detected from a fresh 0->1 edge.
        pulse_miss(0, 1);
        check("pre-reset score_1", int'(score_1), 1);
        rst = 1;
        #2;
        check("async reset state", int'(state), 0);
        check("async reset score_1", int'(score_1), 0);
        step();
        rst = 0;
        step();
        check("post-reset idle", int'(state), 0);
        press(1, 4'd5);
        check("post-reset serve", int'(state), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5: points needed to win; legal range 1..15.
REQ-002 Parameter PADDLE_MAX, default 400: maximum paddle top-edge Y, in pixels.
REQ-003 Parameter PADDLE_STEP, default 4: pixels moved per frame while a direction key is held.
REQ-004 Parameter POINT_FRAMES, default 60: number of frames spent in POINT.
REQ-005 clk  input  1  25 MHz system clock (CLOCK_25 domain).
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 keys_1 / keys_2  input  4  player 1/2 keypad keycode.
REQ-009 key_pressed_1 / key_pressed_2  input  1  player 1/2 key-held level.
REQ-010 miss_left / miss_right  input  1  one-cycle pulse: ball passed the player 1 (left) or player 2 (right) edge.
REQ-011 paddle_1_y / paddle_2_y  output  9  paddle top-edge Y.
REQ-012 score_1 / score_2  output  4  player scores.
REQ-013 ball_en  output  1  ball motion enable.
REQ-014 ball_reset  output  1  one-cycle pulse: recentre the ball.
REQ-015 serve_dir  output  1  serve direction; 0 = toward player 2, 1 = toward player 1.
REQ-016 state  output  3  current state encoding.
REQ-017 winner  output  2  game winner; 0 = none, 1 = player 1, 2 = player 2.

Function
REQ-018 Key event definitions:
- Key event = rising edge of key_pressed_N; keys_N is sampled in the same cycle.
- Keycode 5 = serve; keycode 0 = pause.
- Keycode 2 = up and keycode 8 = down; these are level-held.
REQ-019 State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSE=5.
REQ-020 Transitions:
- IDLE->SERVE on a serve event from either player.
- SERVE->PLAY on a serve event from the serving player only; player 2 serves when serve_dir=0, player 1 serves when serve_dir=1.
- PLAY->POINT on a miss pulse.
- POINT->OVER or POINT->SERVE after POINT_FRAMES frame_ticks.
- OVER->IDLE on any serve event.
REQ-021 ball_en=1 only in PLAY.
REQ-022 ball_reset pulses exactly one cycle on every entry into SERVE.
REQ-023 Paddle movement:
- Paddles update only on frame_tick, only in SERVE or PLAY.
- While the player holds up (and key_pressed is high): paddle -= PADDLE_STEP, saturating at 0.
- While the player holds down: paddle += PADDLE_STEP, saturating at PADDLE_MAX.
REQ-024 Miss scoring in PLAY:
- miss_left: score_2 increments and serve_dir becomes 1.
- miss_right: score_1 increments and serve_dir becomes 0.
- Scores saturate at 15.
REQ-025 miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, enter POINT.
REQ-026 Miss pulses outside PLAY are ignored.
REQ-027 POINT counts frame_ticks. On the POINT_FRAMES-th tick:
- If either score >= WIN_SCORE: go to OVER and set winner.
- Otherwise: go to SERVE.
REQ-028 Entry into IDLE clears both scores, clears winner, and centres both paddles at PADDLE_MAX/2.
REQ-029 A serve event and a miss pulse in the same cycle in PLAY: the miss takes priority.
REQ-030 Simultaneous serve events from both players are treated as one serve event.

Reset
REQ-031 rst asynchronously forces:
- state=IDLE
- paddles=PADDLE_MAX/2
- scores=0, winner=0, serve_dir=0
- ball_en=0, ball_reset=0
- POINT counter=0
- key-edge history=0
REQ-032 rst asserted mid-game discards all progress; the first key event after release is detected only from a 0->1 transition of key_pressed.

Configuration
REQ-033 Macro PONG_PAUSE_EN defined:
- In PLAY, a pause event enters PAUSE: ball_en=0, paddles frozen, miss pulses ignored.
- In PAUSE, a pause event returns to PLAY.
REQ-034 PONG_PAUSE_EN undefined: keycode 0 is ignored and PAUSE is unreachable.

Verification
REQ-035 Reset, then player 1 presses key 5 -> state 0->1 and ball_reset pulses one cycle; player 1 presses 5 again -> stays SERVE; player 2 presses 5 -> PLAY, ball_en=1.
REQ-036 In PLAY, hold key 2 on player 1 for 60 frame_ticks from Y=200 -> paddle_1_y reaches 0 after 50 ticks and stays 0.
REQ-037 In PLAY, pulse miss_right -> score_1=1, serve_dir=0, POINT; after 60 frame_ticks -> SERVE with ball_reset pulse.
REQ-038 Score 4-0, then miss_right -> score_1=5; after 60 ticks -> OVER, winner=1; serve event -> IDLE, scores 0, paddles 200.
REQ-039 Pulse miss_left and miss_right together in PLAY -> scores unchanged, serve_dir unchanged, POINT.
REQ-040 With PONG_PAUSE_EN: key 0 in PLAY -> PAUSE, ball_en=0; miss_left ignored; key 0 -> PLAY. Without the macro: key 0 -> no state change.
